// File: rtl/demux_pkg.sv
// Shared types and sizes for the round-robin 1-to-4 dispatch block.
package demux_pkg;
    localparam int N_DEST = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;
endpackage

// File: rtl/demux_1to4.sv
// Generic 1-to-4 demultiplexer: routes D to output Y[S], other outputs low.
// Purely combinational.
module demux_1to4
    import demux_pkg::*;
(
    input  logic              d,
    input  logic [SEL_W-1:0]  s,
    output logic [N_DEST-1:0] y
);
    always_comb begin
        y    = '0;
        y[s] = d;
    end
endmodule

// File: rtl/rr_pick4.sv
// Rotating first-set search over a 4-bit mask, starting at 'start'.
// Purely combinational.
module rr_pick4
    import demux_pkg::*;
(
    input  logic [N_DEST-1:0] mask,
    input  logic [SEL_W-1:0]  start,
    output logic [SEL_W-1:0]  pick,
    output logic              any
);
    always_comb begin
        pick = '0;
        any  = 1'b0;
        // Walk from the farthest offset down so the nearest enabled slot wins.
        for (int i = N_DEST - 1; i >= 0; i--) begin
            if (mask[start + SEL_W'(i)]) begin
                pick = start + SEL_W'(i);
                any  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/demux_rr_dispatch.sv
// Single-entry dispatcher: accepts one beat, holds it for a round-robin or fixed destination.
// Accept-to-valid latency 1 cycle, 1 beat/cycle when the held beat drains in the same cycle.
// Optional per-destination delivery counters on cnt_o when DEMUX_DISPATCH_CNT_EN is defined.
module demux_rr_dispatch
    import demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                cfg_fixed,
    input  logic [SEL_W-1:0]    cfg_sel,
    input  logic [N_DEST-1:0]   en_mask,
    output logic [N_DEST-1:0]   out_valid,
    input  logic [N_DEST-1:0]   out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [SEL_W-1:0]    sel_o,
    output logic                busy
`ifdef DEMUX_DISPATCH_CNT_EN
    ,
    output logic [N_DEST*CNT_W-1:0] cnt_o
`endif
);
    state_t              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0]   data_q, data_d;

    logic                release_w;
    logic                can_pick;
    logic                accept;
    logic [SEL_W-1:0]    rr_start;
    logic [SEL_W-1:0]    rr_pick;
    logic                rr_any;
    logic [SEL_W-1:0]    pick;

    assign busy      = (state_q == HOLD);
    assign release_w = busy & out_ready[sel_q];
    assign can_pick  = cfg_fixed ? en_mask[cfg_sel] : (|en_mask);
    assign in_ready  = can_pick & (~busy | release_w);
    assign accept    = in_valid & in_ready;
    // A draining beat advances the search origin within the same cycle.
    assign rr_start  = release_w ? (sel_q + SEL_W'(1)) : rr_ptr_q;
    assign pick      = cfg_fixed ? cfg_sel : rr_pick;

    rr_pick4 u_pick (
        .mask  (en_mask),
        .start (rr_start),
        .pick  (rr_pick),
        .any   (rr_any)
    );

    demux_1to4 u_vld (
        .d (busy),
        .s (sel_q),
        .y (out_valid)
    );

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        data_d   = data_q;
        rr_ptr_d = rr_ptr_q;
        if (release_w && !cfg_fixed) begin
            rr_ptr_d = sel_q + SEL_W'(1);
        end
        if (accept) begin
            state_d = HOLD;
            sel_d   = pick;
            data_d  = in_data;
        end else if (release_w) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            rr_ptr_q <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
            data_q   <= data_d;
        end
    end

    assign out_data = data_q;
    assign sel_o    = sel_q;

`ifdef DEMUX_DISPATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q [N_DEST];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_DEST; k++) cnt_q[k] <= '0;
        end else if (release_w) begin
            cnt_q[sel_q] <= cnt_q[sel_q] + CNT_W'(1);
        end
    end

    for (genvar g = 0; g < N_DEST; g++) begin : g_cnt
        assign cnt_o[g*CNT_W +: CNT_W] = cnt_q[g];
    end
`endif
endmodule

// File: tb/tb_demux_rr_dispatch.sv
// Directed-vector bench for demux_rr_dispatch; counter checks run when DEMUX_DISPATCH_CNT_EN is defined.
module tb_demux_rr_dispatch;
`ifdef DEMUX_DISPATCH_CNT_EN
    localparam int CW = 4;
`else
    localparam int CW = 16;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       cfg_fixed;
    logic [1:0] cfg_sel;
    logic [3:0] en_mask;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [7:0] out_data;
    logic [1:0] sel_o;
    logic       busy;
`ifdef DEMUX_DISPATCH_CNT_EN
    logic [4*CW-1:0] cnt_o;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    demux_rr_dispatch #(.DATA_W(8), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .cfg_fixed (cfg_fixed),
        .cfg_sel   (cfg_sel),
        .en_mask   (en_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sel_o     (sel_o),
        .busy      (busy)
`ifdef DEMUX_DISPATCH_CNT_EN
        ,
        .cnt_o     (cnt_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected destinations for a continuous stream with en_mask=1010 starting at rr_ptr=0.
    logic [1:0] skip_exp [4];

    initial begin
        skip_exp[0] = 2'd1; skip_exp[1] = 2'd3; skip_exp[2] = 2'd1; skip_exp[3] = 2'd3;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        cfg_fixed = 1'b0;
        cfg_sel   = 2'd0;
        en_mask   = 4'b1111;
        out_ready = 4'b1111;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_busy",      32'(busy),      32'h0);
        chk("rst_sel",       32'(sel_o),     32'h0);
        chk("rst_data",      32'(out_data),  32'h0);
        chk("rst_in_ready",  32'(in_ready),  32'h1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Round-robin over all four destinations, one beat per cycle.
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 8'hA0 + 8'(i);
            #1;
            chk("rr_in_ready", 32'(in_ready), 32'h1);
            tick();
            chk("rr_sel",   32'(sel_o),     32'(i % 4));
            chk("rr_vld",   32'(out_valid), 32'(1 << (i % 4)));
            chk("rr_data",  32'(out_data),  32'(8'hA0 + 8'(i)));
        end
        in_valid = 1'b0;
        tick();
        chk("rr_drain_busy", 32'(busy), 32'h0);

        // Disabled destinations are skipped.
        en_mask  = 4'b1010;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'hB0 + 8'(i);
            tick();
            chk("skip_sel", 32'(sel_o),     32'(skip_exp[i]));
            chk("skip_vld", 32'(out_valid), 32'(4'b0001 << skip_exp[i]));
        end
        in_valid = 1'b0;
        tick();

        // Backpressure on destination 2.
        en_mask   = 4'b1111;
        out_ready = 4'b1011;
        in_valid  = 1'b1;
        in_data   = 8'h10; tick();
        chk("bp_sel0", 32'(sel_o), 32'h0);
        in_data   = 8'h11; tick();
        chk("bp_sel1", 32'(sel_o), 32'h1);
        in_data   = 8'h55; tick();
        chk("bp_sel2", 32'(sel_o), 32'h2);
        in_data   = 8'h66;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", 32'(in_ready),  32'h0);
            chk("bp_data",     32'(out_data),  32'h55);
            chk("bp_busy",     32'(busy),      32'h1);
            chk("bp_vld",      32'(out_valid), 32'h4);
            tick();
        end
        out_ready = 4'b1111;
        #1;
        chk("bp_rel_in_ready", 32'(in_ready), 32'h1);
        tick();
        chk("bp_next_sel",  32'(sel_o),    32'h3);
        chk("bp_next_data", 32'(out_data), 32'h66);
        in_valid = 1'b0;
        tick();

        // Fixed destination.
        cfg_fixed = 1'b1;
        cfg_sel   = 2'd2;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'hC0 + 8'(i);
            tick();
            chk("fix_sel",  32'(sel_o),     32'h2);
            chk("fix_vld",  32'(out_valid), 32'h4);
            chk("fix_data", 32'(out_data),  32'(8'hC0 + 8'(i)));
        end
        en_mask = 4'b1011;
        #1;
        chk("fix_stall_rdy", 32'(in_ready), 32'h0);
        tick();
        chk("fix_stall_busy", 32'(busy),     32'h0);
        chk("fix_stall_rdy2", 32'(in_ready), 32'h0);
        cfg_fixed = 1'b0;
        #1;
        chk("rr_resume_rdy", 32'(in_ready), 32'h1);
        tick();
        chk("rr_resume_busy", 32'(busy), 32'h1);
        chk("rr_resume_en",   32'(out_valid & ~en_mask), 32'h0);
        in_valid = 1'b0;
        tick();

        // Asynchronous reset while a beat is held.
        en_mask   = 4'b1111;
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_data   = 8'h77;
        tick();
        chk("pre_rst_busy", 32'(busy), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vld",  32'(out_valid), 32'h0);
        chk("arst_busy", 32'(busy),      32'h0);
        chk("arst_sel",  32'(sel_o),     32'h0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        in_data   = 8'h88;
        tick();
        chk("post_rst_sel",  32'(sel_o),    32'h0);
        chk("post_rst_data", 32'(out_data), 32'h88);
        in_valid = 1'b0;
        tick();

`ifdef DEMUX_DISPATCH_CNT_EN
        // 17 deliveries to destination 0 wrap a 4-bit counter to 1.
        rst_n = 1'b0;
        #1;
        chk("cnt_rst", 32'(cnt_o), 32'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        cfg_fixed = 1'b1;
        cfg_sel   = 2'd0;
        in_valid  = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        in_valid = 1'b0;
        tick();
        chk("cnt_dest0", 32'(cnt_o[3:0]),   32'h1);
        chk("cnt_other", 32'(cnt_o[15:4]),  32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
